// File: rtl/prg_saver_if.sv
// Host/memory bus of the PRG saver.
// ioctl_*: the host side. ioctl_rd is a one-cycle request strobe; it is only
// accepted while ioctl_wait is low, and the host never strobes while
// ioctl_wait is high. The answer appears on ioctl_din and stays there until
// the next accepted read.
// dma_*: the memory side. dma_rd is a one-cycle strobe, and dma_dout carries
// the byte at dma_addr exactly one cycle after that strobe.
interface prg_saver_if;
  logic        ioctl_upload;
  logic        ioctl_rd;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_din;
  logic        ioctl_wait;
  logic [15:0] dma_addr;
  logic        dma_rd;
  logic [7:0]  dma_dout;
  logic [16:0] file_size;
  logic        err;

  // Host plus memory environment: drives requests and memory data.
  modport master (
    output ioctl_upload, ioctl_rd, ioctl_addr, dma_dout,
    input  ioctl_din, ioctl_wait, dma_addr, dma_rd, file_size, err
  );

  // The saver itself.
  modport slave (
    input  ioctl_upload, ioctl_rd, ioctl_addr, dma_dout,
    output ioctl_din, ioctl_wait, dma_addr, dma_rd, file_size, err
  );
endinterface

// File: rtl/prg_saver.sv
// Streams the BASIC program of a PET out to the host as a PRG file.
// On an upload request the two zero-page pointers (program start/end) are
// read over DMA. The file is then the 2-byte load address followed by the
// bytes start..end-1, each body byte fetched from memory on demand.
module prg_saver #(
  parameter logic [15:0] PTR_START = 16'h0028,
  parameter logic [15:0] PTR_END   = 16'h002A,
  parameter logic [15:0] RAM_TOP   = 16'h8000
) (
  input  logic       clk,
  input  logic       reset_n,
  prg_saver_if.slave bus,
  output logic [2:0] state_dbg
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] PTR   = 3'd1;
  localparam logic [2:0] READY = 3'd2;
  localparam logic [2:0] FETCH = 3'd3;
  localparam logic [2:0] LATCH = 3'd4;

  logic [2:0]  state;
  logic [2:0]  ptr_cnt;     // even: strobe visible, odd: its data valid
  logic        upload_q;
  logic        armed;       // upload has been seen low since reset
  logic        loaded;      // both pointers have been read
  logic        err_rd;      // a read fell past the end of the file
  logic [15:0] start_ptr;
  logic [15:0] end_ptr;
  logic [7:0]  din_r;
  logic        wait_r;
  logic [15:0] dma_addr_r;
  logic        dma_rd_r;

  logic        upload_rise;
  logic        upload_fall;
  logic        ptr_valid;
  logic [16:0] size_calc;
  logic        in_body;
  logic [15:0] body_addr;

  assign bus.ioctl_din  = din_r;
  assign bus.ioctl_wait = wait_r;
  assign bus.dma_addr   = dma_addr_r;
  assign bus.dma_rd     = dma_rd_r;
  assign state_dbg      = state;

  // Upload edges; a level still high after reset is not an edge until it has dropped.
  always_comb begin
    upload_rise = bus.ioctl_upload & ~upload_q & armed;
    upload_fall = ~bus.ioctl_upload & upload_q;
  end

  // Pointer validity, file size and body address arithmetic.
  always_comb begin
    ptr_valid = (start_ptr < end_ptr) && (end_ptr <= RAM_TOP);
    size_calc = 17'd2;
    if (ptr_valid) begin
      size_calc = {1'b0, end_ptr} - {1'b0, start_ptr} + 17'd2;
    end
    in_body   = (bus.ioctl_addr >= 25'd2) &&
                (bus.ioctl_addr < {8'd0, bus.file_size});
    body_addr = start_ptr + bus.ioctl_addr[15:0] - 16'd2;
  end

  // Size and error only become meaningful once the pointers are loaded.
  always_comb begin
    bus.file_size = loaded ? size_calc : 17'd0;
    bus.err       = err_rd | (loaded & ~ptr_valid);
  end

  // Control FSM: pointer fetch, then serving host reads.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      ptr_cnt    <= 3'd0;
      upload_q   <= 1'b0;
      armed      <= 1'b0;
      loaded     <= 1'b0;
      err_rd     <= 1'b0;
      start_ptr  <= 16'd0;
      end_ptr    <= 16'd0;
      din_r      <= 8'd0;
      wait_r     <= 1'b0;
      dma_addr_r <= 16'd0;
      dma_rd_r   <= 1'b0;
    end else begin
      upload_q <= bus.ioctl_upload;
      if (!bus.ioctl_upload) begin
        armed <= 1'b1;
      end
      dma_rd_r <= 1'b0;
      if (upload_fall) begin
        // Abandon whatever is in flight, including a pending DMA read.
        state  <= IDLE;
        wait_r <= 1'b0;
      end else if (upload_rise) begin
        state      <= PTR;
        wait_r     <= 1'b1;
        err_rd     <= 1'b0;
        loaded     <= 1'b0;
        ptr_cnt    <= 3'd0;
        dma_addr_r <= PTR_START;
        dma_rd_r   <= 1'b1;
      end else begin
        case (state)
          PTR: begin
            ptr_cnt <= ptr_cnt + 3'd1;
            case (ptr_cnt)
              3'd1: begin
                start_ptr[7:0] <= bus.dma_dout;
                dma_addr_r     <= PTR_START + 16'd1;
                dma_rd_r       <= 1'b1;
              end
              3'd3: begin
                start_ptr[15:8] <= bus.dma_dout;
                dma_addr_r      <= PTR_END;
                dma_rd_r        <= 1'b1;
              end
              3'd5: begin
                end_ptr[7:0] <= bus.dma_dout;
                dma_addr_r   <= PTR_END + 16'd1;
                dma_rd_r     <= 1'b1;
              end
              3'd7: begin
                end_ptr[15:8] <= bus.dma_dout;
                loaded        <= 1'b1;
                wait_r        <= 1'b0;
                state         <= READY;
              end
              default: begin
              end
            endcase
          end
          READY: begin
            if (bus.ioctl_rd) begin
              if (bus.ioctl_addr == 25'd0) begin
                din_r <= start_ptr[7:0];
              end else if (bus.ioctl_addr == 25'd1) begin
                din_r <= start_ptr[15:8];
              end else if (in_body) begin
                wait_r     <= 1'b1;
                dma_addr_r <= body_addr;
                dma_rd_r   <= 1'b1;
                state      <= FETCH;
              end else begin
                din_r  <= 8'h00;
                err_rd <= 1'b1;
              end
            end
          end
          FETCH: begin
            state <= LATCH;
          end
          LATCH: begin
            din_r  <= bus.dma_dout;
            wait_r <= 1'b0;
            state  <= READY;
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule
